// File: rtl/vx_ram_port_arbiter.sv
// Round-robin write/read arbiter in front of a private simple dual-port RAM.
// After reset the array can optionally be swept to INIT_VALUE before any traffic is accepted.
module vx_ram_port_arbiter #(
  parameter int               NUM_REQS    = 4,
  parameter int               SIZE        = 64,
  parameter int               DATAW       = 32,
  parameter int               WRENW       = 4,
  parameter int               ADDRW       = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter bit               INIT_ENABLE = 1'b1,
  parameter logic [DATAW-1:0] INIT_VALUE  = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      init_done,
  input  logic [NUM_REQS-1:0]       wr_valid,
  input  logic [NUM_REQS*ADDRW-1:0] wr_addr,
  input  logic [NUM_REQS*DATAW-1:0] wr_data,
  input  logic [NUM_REQS*WRENW-1:0] wr_wren,
  output logic [NUM_REQS-1:0]       wr_ready,
  input  logic [NUM_REQS-1:0]       rd_valid,
  input  logic [NUM_REQS*ADDRW-1:0] rd_addr,
  output logic [NUM_REQS-1:0]       rd_ready,
  output logic [NUM_REQS-1:0]       rsp_valid,
  output logic [DATAW-1:0]          rsp_data
);

  localparam int PTRW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int LANEW = DATAW / WRENW;

  if (DATAW % WRENW != 0) begin : g_bad_wrenw
    $error("DATAW must be a multiple of WRENW");
  end
  if (NUM_REQS < 1 || NUM_REQS > 16) begin : g_bad_reqs
    $error("NUM_REQS must be in 1..16");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q;
  logic [ADDRW-1:0]  init_cnt_q;
  logic              init_done_q;
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NUM_REQS-1:0] rsp_valid_q;
  logic [DATAW-1:0]  rsp_data_q;
  logic [DATAW-1:0]  mem_q [SIZE];

  logic [PTRW:0]     wr_pick, rd_pick;
  logic [PTRW-1:0]   wr_sel, rd_sel;
  logic              wr_gnt, rd_gnt;
  logic              mem_we;
  logic [ADDRW-1:0]  mem_waddr;
  logic [DATAW-1:0]  mem_wdata;
  logic [WRENW-1:0]  mem_wren;
  logic [ADDRW-1:0]  rd_addr_sel;

  // Returns {found, index}: first set request at or above ptr, wrapping modulo NUM_REQS.
  function automatic logic [PTRW:0] rr_pick(input logic [NUM_REQS-1:0] req,
                                           input logic [PTRW-1:0]     ptr);
    logic [PTRW:0]   res;
    logic [PTRW-1:0] cand;
    res = '0;
    for (int unsigned k = 0; k < NUM_REQS; k++) begin
      cand = PTRW'((32'(ptr) + k) % 32'(NUM_REQS));
      if (!res[PTRW] && req[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  always_comb begin
    wr_pick  = rr_pick(wr_valid, wr_ptr_q);
    rd_pick  = rr_pick(rd_valid, rd_ptr_q);
    wr_sel   = wr_pick[PTRW-1:0];
    rd_sel   = rd_pick[PTRW-1:0];
    wr_gnt   = (state_q == ST_RUN) && wr_pick[PTRW];
    rd_gnt   = (state_q == ST_RUN) && rd_pick[PTRW];
    wr_ready = wr_gnt ? (NUM_REQS'(1) << wr_sel) : '0;
    rd_ready = rd_gnt ? (NUM_REQS'(1) << rd_sel) : '0;
    wr_ptr_d = wr_gnt ? PTRW'((32'(wr_sel) + 32'd1) % 32'(NUM_REQS)) : wr_ptr_q;
    rd_ptr_d = rd_gnt ? PTRW'((32'(rd_sel) + 32'd1) % 32'(NUM_REQS)) : rd_ptr_q;
    rd_addr_sel = rd_addr[32'(rd_sel)*ADDRW +: ADDRW];
    if (state_q == ST_INIT) begin
      mem_we    = INIT_ENABLE;
      mem_waddr = init_cnt_q;
      mem_wdata = INIT_VALUE;
      mem_wren  = '1;
    end else begin
      mem_we    = wr_gnt;
      mem_waddr = wr_addr[32'(wr_sel)*ADDRW +: ADDRW];
      mem_wdata = wr_data[32'(wr_sel)*DATAW +: DATAW];
      mem_wren  = wr_wren[32'(wr_sel)*WRENW +: WRENW];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rd_ready;
      // Reads sample the array before this edge's write lands: read-first on collision.
      if (rd_gnt) rsp_data_q <= mem_q[rd_addr_sel];
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + ADDRW'(1);
          if (!INIT_ENABLE || init_cnt_q == ADDRW'(SIZE - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned l = 0; l < WRENW; l++) begin
      if (mem_we && mem_wren[l]) mem_q[mem_waddr][l*LANEW +: LANEW] <= mem_wdata[l*LANEW +: LANEW];
    end
  end

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_hs_chk
    a_wr_hold: assert property (@(posedge clk) disable iff (!reset)
                                (wr_valid[g] && !wr_ready[g]) |=> wr_valid[g]);
    a_rd_hold: assert property (@(posedge clk) disable iff (!reset)
                                (rd_valid[g] && !rd_ready[g]) |=> rd_valid[g]);
  end

endmodule
